// File: rtl/calc_frame_controller.sv
// Calculator frame sequencer: assembles opcode/op1/op2 frames from the UART byte
// stream, drives the ALU, and returns a status byte plus result bytes over valid/ready.
module calc_frame_controller #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [1:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_error,
   output logic             busy,
   output logic             done,
   output logic             frame_timeout
);

   localparam int unsigned N   = WIDTH / 8;
   localparam int unsigned BCW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(N - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_OP1,
      S_GET_OP2,
      S_EXEC,
      S_SEND_STATUS,
      S_SEND_RESULT
   } state_t;

   state_t           r_state, w_state_nx;
   logic [1:0]       r_opcode, w_opcode_nx;
   logic             r_bad_op, w_bad_op_nx;
   logic [WIDTH-1:0] r_op1, w_op1_nx;
   logic [WIDTH-1:0] r_op2, w_op2_nx;
   logic [WIDTH-1:0] r_res, w_res_nx;
   logic [7:0]       r_tx_data, w_tx_data_nx;
   logic             r_tx_valid, w_tx_valid_nx;
   logic [BCW-1:0]   r_byte_cnt, w_byte_cnt_nx;
   logic [TCW-1:0]   r_idle_cnt, w_idle_cnt_nx;
   logic             r_timeout, w_timeout_nx;
   logic             r_busy;
   logic             w_xfer;
   logic             w_done;

   assign w_xfer = r_tx_valid & tx_ready;

   always_comb begin
      w_state_nx    = r_state;
      w_opcode_nx   = r_opcode;
      w_bad_op_nx   = r_bad_op;
      w_op1_nx      = r_op1;
      w_op2_nx      = r_op2;
      w_res_nx      = r_res;
      w_tx_data_nx  = r_tx_data;
      w_tx_valid_nx = r_tx_valid;
      w_byte_cnt_nx = r_byte_cnt;
      w_idle_cnt_nx = '0;
      w_timeout_nx  = 1'b0;
      w_done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_byte_cnt_nx = '0;
            if (rx_valid) begin
               w_opcode_nx = rx_data[1:0];
               w_bad_op_nx = |rx_data[7:2];
               w_state_nx  = S_GET_OP1;
            end
         end

         S_GET_OP1, S_GET_OP2: begin
            if (rx_valid) begin
               if (r_state == S_GET_OP1)
                  w_op1_nx = (r_op1 << 8) | WIDTH'(rx_data);
               else
                  w_op2_nx = (r_op2 << 8) | WIDTH'(rx_data);
               if (r_byte_cnt == LAST_BYTE) begin
                  w_byte_cnt_nx = '0;
                  w_state_nx    = (r_state == S_GET_OP1) ? S_GET_OP2 : S_EXEC;
               end else begin
                  w_byte_cnt_nx = r_byte_cnt + 1'b1;
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               // A byte on the threshold cycle wins over the timeout.
               if (r_idle_cnt == TO_LAST) begin
                  w_timeout_nx  = 1'b1;
                  w_byte_cnt_nx = '0;
                  w_state_nx    = S_IDLE;
               end else begin
                  w_idle_cnt_nx = r_idle_cnt + 1'b1;
               end
            end
         end

         S_EXEC: begin
            w_res_nx      = alu_result;
            w_tx_data_nx  = r_bad_op ? 8'h02 : (alu_error ? 8'h01 : 8'h00);
            w_tx_valid_nx = 1'b1;
            w_state_nx    = S_SEND_STATUS;
         end

         S_SEND_STATUS: begin
            if (w_xfer) begin
               if (r_tx_data == 8'h00) begin
                  w_tx_data_nx  = r_res[WIDTH-1 -: 8];
                  w_res_nx      = r_res << 8;
                  w_byte_cnt_nx = '0;
                  w_state_nx    = S_SEND_RESULT;
               end else begin
                  w_tx_valid_nx = 1'b0;
                  w_done        = 1'b1;
                  w_state_nx    = S_IDLE;
               end
            end
         end

         S_SEND_RESULT: begin
            if (w_xfer) begin
               if (r_byte_cnt == LAST_BYTE) begin
                  w_tx_valid_nx = 1'b0;
                  w_byte_cnt_nx = '0;
                  w_done        = 1'b1;
                  w_state_nx    = S_IDLE;
               end else begin
                  w_tx_data_nx  = r_res[WIDTH-1 -: 8];
                  w_res_nx      = r_res << 8;
                  w_byte_cnt_nx = r_byte_cnt + 1'b1;
               end
            end
         end

         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_opcode   <= '0;
         r_bad_op   <= 1'b0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_res      <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_byte_cnt <= '0;
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_opcode   <= w_opcode_nx;
         r_bad_op   <= w_bad_op_nx;
         r_op1      <= w_op1_nx;
         r_op2      <= w_op2_nx;
         r_res      <= w_res_nx;
         r_tx_data  <= w_tx_data_nx;
         r_tx_valid <= w_tx_valid_nx;
         r_byte_cnt <= w_byte_cnt_nx;
         r_idle_cnt <= w_idle_cnt_nx;
         r_timeout  <= w_timeout_nx;
         r_busy     <= (w_state_nx != S_IDLE);
      end
   end

   assign tx_data       = r_tx_data;
   assign tx_valid      = r_tx_valid;
   assign alu_opcode    = r_opcode;
   assign alu_op1       = r_op1;
   assign alu_op2       = r_op2;
   assign busy          = r_busy;
   assign done          = w_done;
   assign frame_timeout = r_timeout;

endmodule
